// File: rtl/cnn_accel_quad_if.sv
// Host-side bundle of the CNN quad front end: job handshake, config load,
// sequence-memory readback, pixel/result streams and the cascade link.
interface cnn_accel_quad_if #(
    parameter int C_PIXEL_WIDTH    = 16,
    parameter int C_NUM_AWE        = 4,
    parameter int C_NUM_CE_PER_AWE = 2,
    parameter int C_BRAM_DEPTH     = 512
);
    localparam int W  = C_NUM_AWE * C_NUM_CE_PER_AWE * C_PIXEL_WIDTH;
    localparam int AW = $clog2(C_BRAM_DEPTH);
    localparam int SW = (C_NUM_AWE > 1) ? $clog2(C_NUM_AWE) : 1;

    logic                 job_start;
    logic                 job_accept;
    logic [31:0]          job_parameters;
    logic                 job_fetch_request;
    logic                 job_fetch_ack;
    logic                 job_fetch_complete;
    logic                 job_complete;
    logic                 job_complete_ack;

    logic [W-1:0]         cascade_in_data;
    logic                 cascade_in_valid;
    logic                 cascade_in_ready;
    logic [W-1:0]         cascade_out_data;
    logic                 cascade_out_valid;
    logic                 cascade_out_ready;

    logic [C_NUM_AWE-1:0] config_valid;
    logic [C_NUM_AWE-1:0] config_accept;
    logic [W-1:0]         config_data;

    logic [SW-1:0]        seq_rd_awe;
    logic [AW-1:0]        seq_rd_addr;
    logic [W-1:0]         seq_rd_data;

    logic                 result_valid;
    logic                 result_accept;
    logic [W-1:0]         result_data;

    logic                 pixel_valid;
    logic                 pixel_ready;
    logic [W-1:0]         pixel_data;

    modport master (
        output job_start, job_parameters, job_fetch_ack, job_fetch_complete, job_complete_ack,
        input  job_accept, job_fetch_request, job_complete,
        output cascade_in_data, cascade_in_valid, cascade_out_ready,
        input  cascade_in_ready, cascade_out_data, cascade_out_valid,
        output config_valid, config_data,
        input  config_accept,
        output seq_rd_awe, seq_rd_addr,
        input  seq_rd_data,
        input  result_valid, result_data,
        output result_accept,
        output pixel_valid, pixel_data,
        input  pixel_ready
    );

    modport slave (
        input  job_start, job_parameters, job_fetch_ack, job_fetch_complete, job_complete_ack,
        output job_accept, job_fetch_request, job_complete,
        input  cascade_in_data, cascade_in_valid, cascade_out_ready,
        output cascade_in_ready, cascade_out_data, cascade_out_valid,
        input  config_valid, config_data,
        output config_accept,
        input  seq_rd_awe, seq_rd_addr,
        output seq_rd_data,
        output result_valid, result_data,
        input  result_accept,
        input  pixel_valid, pixel_data,
        output pixel_ready
    );
endinterface

// File: rtl/cnn_accel_quad.sv
// Job-level front end of one CNN accelerator quad: per-AWE sequence memory load,
// row-by-row pixel fetch forwarded to a result register, and a cascade register.
module cnn_accel_quad #(
    parameter int C_PIXEL_WIDTH    = 16,
    parameter int C_NUM_AWE        = 4,
    parameter int C_NUM_CE_PER_AWE = 2,
    parameter int C_BRAM_DEPTH     = 512
) (
    input  logic           clk_if,
    input  logic           rst,
    cnn_accel_quad_if.slave bus
);
    localparam int W  = C_NUM_AWE * C_NUM_CE_PER_AWE * C_PIXEL_WIDTH;
    localparam int AW = $clog2(C_BRAM_DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW + 1)'(C_BRAM_DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH_REQ, FETCH_DATA, DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic [9:0]           rows_m1;
    logic [9:0]           cols_m1;
    logic [10:0]          row_cnt;
    logic [10:0]          beat_cnt;
    logic [AW:0]          wp [C_NUM_AWE];
    logic [W-1:0]         mem [C_NUM_AWE][C_BRAM_DEPTH];
    logic [W-1:0]         seq_rd_q;
    logic [W-1:0]         result_q;
    logic                 result_valid_q;
    logic [W-1:0]         cascade_q;
    logic                 cascade_valid_q;
    logic [C_NUM_AWE-1:0] cfg_accept;
    logic                 pixel_fire;
    logic                 job_done_ack;
    logic                 unused_reserved;

    assign unused_reserved = ^bus.job_parameters[31:20];

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state            = state;
        bus.job_accept        = 1'b0;
        bus.job_fetch_request = 1'b0;
        bus.job_complete      = 1'b0;
        bus.pixel_ready       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.job_start && rst) begin
                    bus.job_accept = 1'b1;
                    next_state     = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                bus.job_fetch_request = 1'b1;
                if (bus.job_fetch_ack) next_state = FETCH_DATA;
            end
            FETCH_DATA: begin
                bus.pixel_ready = (beat_cnt < ({1'b0, cols_m1} + 11'd1)) &&
                                  (!result_valid_q || bus.result_accept);
                // row_cnt still holds the count before this row is added
                if (bus.job_fetch_complete)
                    next_state = (row_cnt == {1'b0, rows_m1}) ? DONE : FETCH_REQ;
            end
            DONE: begin
                bus.job_complete = 1'b1;
                if (bus.job_complete_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    assign pixel_fire   = bus.pixel_valid && bus.pixel_ready;
    assign job_done_ack = (state == DONE) && bus.job_complete_ack;

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            rows_m1  <= '0;
            cols_m1  <= '0;
            row_cnt  <= '0;
            beat_cnt <= '0;
        end else begin
            if (bus.job_accept) begin
                rows_m1 <= bus.job_parameters[9:0];
                cols_m1 <= bus.job_parameters[19:10];
                row_cnt <= '0;
            end else if (state == FETCH_DATA && bus.job_fetch_complete) begin
                row_cnt <= row_cnt + 11'd1;
            end
            if (state == FETCH_REQ && bus.job_fetch_ack) beat_cnt <= '0;
            else if (pixel_fire)                         beat_cnt <= beat_cnt + 11'd1;
        end
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            result_valid_q <= 1'b0;
            result_q       <= '0;
        end else if (pixel_fire) begin
            result_valid_q <= 1'b1;
            result_q       <= bus.pixel_data;
        end else if (bus.result_accept) begin
            result_valid_q <= 1'b0;
        end
    end

    assign bus.result_valid = result_valid_q;
    assign bus.result_data  = result_q;

    // Config beats are only taken while no job is running
    always_comb begin
        for (int k = 0; k < C_NUM_AWE; k++)
            cfg_accept[k] = rst && bus.config_valid[k] && (wp[k] < DEPTH_V) && (state == IDLE);
    end

    assign bus.config_accept = cfg_accept;

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < C_NUM_AWE; k++) wp[k] <= '0;
        end else begin
            for (int k = 0; k < C_NUM_AWE; k++) begin
                if (job_done_ack)       wp[k] <= '0;
                else if (cfg_accept[k]) wp[k] <= wp[k] + 1'b1;
            end
        end
    end

    // Sequence memory has no reset so it can map onto block RAM
    always_ff @(posedge clk_if) begin
        for (int k = 0; k < C_NUM_AWE; k++)
            if (cfg_accept[k]) mem[k][wp[k][AW-1:0]] <= bus.config_data;
    end

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) seq_rd_q <= '0;
        else      seq_rd_q <= mem[bus.seq_rd_awe][bus.seq_rd_addr];
    end

    assign bus.seq_rd_data = seq_rd_q;

    assign bus.cascade_in_ready = rst && (!cascade_valid_q || bus.cascade_out_ready);

    always_ff @(posedge clk_if or negedge rst) begin
        if (!rst) begin
            cascade_valid_q <= 1'b0;
            cascade_q       <= '0;
        end else if (bus.cascade_in_ready) begin
            cascade_valid_q <= bus.cascade_in_valid;
            if (bus.cascade_in_valid) cascade_q <= bus.cascade_in_data;
        end
    end

    assign bus.cascade_out_valid = cascade_valid_q;
    assign bus.cascade_out_data  = cascade_q;
endmodule

// File: tb/tb_cnn_accel_quad.sv
// Directed bench for cnn_accel_quad: reset, config load/readback, two jobs
// (full 10x10 with a result stall, and an early-completed row), and cascade.
module tb_cnn_accel_quad;
    localparam int W = 128;

    logic clk_if = 1'b0;
    logic rst    = 1'b0;
    int   testsRun    = 0;
    int   testsFailed = 0;
    int   acceptPulses = 0;

    always #5 clk_if = ~clk_if;

    cnn_accel_quad_if bus ();

    cnn_accel_quad dut (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus)
    );

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus();
        bus.job_start          = 1'b0;
        bus.job_parameters     = '0;
        bus.job_fetch_ack      = 1'b0;
        bus.job_fetch_complete = 1'b0;
        bus.job_complete_ack   = 1'b0;
        bus.cascade_in_data    = '0;
        bus.cascade_in_valid   = 1'b0;
        bus.cascade_out_ready  = 1'b0;
        bus.config_valid       = '0;
        bus.config_data        = '0;
        bus.seq_rd_awe         = '0;
        bus.seq_rd_addr        = '0;
        bus.result_accept      = 1'b0;
        bus.pixel_valid        = 1'b0;
        bus.pixel_data         = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk_if);
        #1;
    endtask

    function automatic logic [W-1:0] cfgBeat(input int idx, input int awe);
        logic [W-1:0] v;
        for (int n = 0; n < 8; n++) v[16*n +: 16] = 16'((awe << 14) | (n << 10) | (idx & 1023));
        return v;
    endfunction

    function automatic logic [W-1:0] pixelBeat(input int r, input int c);
        logic [W-1:0] v;
        for (int l = 0; l < 8; l++) v[16*l +: 16] = 16'((r << 8) | (c << 4) | l);
        return v;
    endfunction

    function automatic logic [W-1:0] cascadeWord(input int i);
        logic [15:0] w;
        w = 16'hC000 + 16'(i);
        return {8{w}};
    endfunction

    // One fetch: request/ack, stream nBeats pixels, then job_fetch_complete
    task automatic runRow(input int r, input int nBeats, input bit stall, input bit expReadyAfter);
        int sent = 0;
        int seen = 0;
        int cyc  = 0;
        checkOutput("fetch_request before ack", bus.job_fetch_request, 1'b1);
        bus.job_fetch_ack = 1'b1;
        nextCycle();
        bus.job_fetch_ack = 1'b0;
        #1;
        checkOutput("fetch_request after ack", bus.job_fetch_request, 1'b0);
        while (seen < nBeats && cyc < 200) begin
            bus.pixel_valid   = (sent < nBeats);
            bus.pixel_data    = pixelBeat(r, sent);
            bus.result_accept = !(stall && cyc >= 1 && cyc <= 3);
            #1;
            if (stall && cyc == 2) checkOutput("pixel_ready during stall", bus.pixel_ready, 1'b0);
            if (bus.job_accept) acceptPulses++;
            if (bus.result_valid && bus.result_accept) begin
                checkOutput($sformatf("result r%0d b%0d", r, seen), bus.result_data, pixelBeat(r, seen));
                seen++;
            end
            if (bus.pixel_valid && bus.pixel_ready) sent++;
            nextCycle();
            cyc++;
        end
        checkOutput($sformatf("row %0d results", r), seen, nBeats);
        checkOutput($sformatf("row %0d beats sent", r), sent, nBeats);
        if (!stall) checkOutput($sformatf("row %0d cycles", r), cyc, nBeats + 1);
        bus.pixel_valid = 1'b1;
        bus.pixel_data  = pixelBeat(r, nBeats);
        #1;
        checkOutput($sformatf("row %0d ready after last", r), bus.pixel_ready, expReadyAfter);
        bus.pixel_valid        = 1'b0;
        bus.job_fetch_complete = 1'b1;
        nextCycle();
        bus.job_fetch_complete = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepted = 0;
        int inIdx    = 0;
        int outIdx   = 0;

        applyStimulus();
        bus.job_start         = 1'b1;
        bus.config_valid      = 4'hF;
        bus.cascade_in_valid  = 1'b1;
        bus.cascade_out_ready = 1'b1;
        bus.pixel_valid       = 1'b1;
        repeat (2) @(posedge clk_if);
        #1;
        checkOutput("rst job_accept", bus.job_accept, 1'b0);
        checkOutput("rst fetch_request", bus.job_fetch_request, 1'b0);
        checkOutput("rst job_complete", bus.job_complete, 1'b0);
        checkOutput("rst config_accept", bus.config_accept, 4'h0);
        checkOutput("rst pixel_ready", bus.pixel_ready, 1'b0);
        checkOutput("rst result_valid", bus.result_valid, 1'b0);
        checkOutput("rst cascade_out_valid", bus.cascade_out_valid, 1'b0);
        checkOutput("rst cascade_in_ready", bus.cascade_in_ready, 1'b0);
        checkOutput("rst result_data", bus.result_data, '0);
        checkOutput("rst cascade_out_data", bus.cascade_out_data, '0);
        checkOutput("rst seq_rd_data", bus.seq_rd_data, '0);

        applyStimulus();
        #2 rst = 1'b1;
        nextCycle();
        checkOutput("idle job_accept", bus.job_accept, 1'b0);
        checkOutput("idle fetch_request", bus.job_fetch_request, 1'b0);
        checkOutput("idle job_complete", bus.job_complete, 1'b0);
        checkOutput("idle pixel_ready", bus.pixel_ready, 1'b0);
        checkOutput("idle result_valid", bus.result_valid, 1'b0);
        checkOutput("idle cascade_in_ready", bus.cascade_in_ready, 1'b1);
        bus.config_valid = 4'b1010;
        #1;
        checkOutput("idle config_accept follows valid", bus.config_accept, 4'b1010);
        bus.config_valid = 4'b0000;
        #1;
        checkOutput("idle config_accept no valid", bus.config_accept, 4'b0000);
        nextCycle();

        for (int i = 0; i <= 512; i++) begin
            bus.config_valid = 4'b0001;
            bus.config_data  = cfgBeat(i, 0);
            #1;
            if (i == 0)   checkOutput("cfg accept beat 0", bus.config_accept[0], 1'b1);
            if (i == 511) checkOutput("cfg accept beat 511", bus.config_accept[0], 1'b1);
            if (i == 512) checkOutput("cfg accept beat 512", bus.config_accept[0], 1'b0);
            if (bus.config_accept[0]) accepted++;
            nextCycle();
        end
        checkOutput("cfg accepted count", accepted, 512);
        for (int i = 0; i < 2; i++) begin
            bus.config_valid = 4'b0010;
            bus.config_data  = cfgBeat(i, 1);
            nextCycle();
        end
        bus.config_valid = 4'b0000;

        bus.seq_rd_awe  = 2'd0;
        bus.seq_rd_addr = 9'd1;
        nextCycle();
        checkOutput("seq_rd awe0 addr1", bus.seq_rd_data, cfgBeat(1, 0));
        bus.seq_rd_awe  = 2'd1;
        bus.seq_rd_addr = 9'd1;
        nextCycle();
        checkOutput("seq_rd awe1 addr1", bus.seq_rd_data, cfgBeat(1, 1));
        bus.seq_rd_awe  = 2'd0;
        bus.seq_rd_addr = 9'd511;
        nextCycle();
        checkOutput("seq_rd awe0 addr511", bus.seq_rd_data, cfgBeat(511, 0));

        bus.job_parameters = {12'hABC, 10'd9, 10'd9};
        bus.job_start      = 1'b1;
        #1;
        checkOutput("job_accept on start", bus.job_accept, 1'b1);
        nextCycle();
        checkOutput("job_accept one cycle", bus.job_accept, 1'b0);
        bus.config_valid = 4'b0100;
        #1;
        checkOutput("config_accept during job", bus.config_accept, 4'b0000);
        bus.config_valid = 4'b0000;
        for (int r = 0; r < 10; r++) begin
            if (r < 9) checkOutput($sformatf("no complete before row %0d", r), bus.job_complete, 1'b0);
            runRow(r, 10, (r == 3), 1'b0);
        end
        checkOutput("job_complete after row 9", bus.job_complete, 1'b1);
        checkOutput("fetch_request in done", bus.job_fetch_request, 1'b0);
        if (bus.job_accept) acceptPulses++;
        nextCycle();
        checkOutput("job_complete held", bus.job_complete, 1'b1);
        bus.job_complete_ack = 1'b1;
        nextCycle();
        bus.job_complete_ack = 1'b0;
        #1;
        checkOutput("job_complete cleared", bus.job_complete, 1'b0);
        checkOutput("held start restarts in idle", bus.job_accept, 1'b1);
        bus.job_start = 1'b0;
        #1;
        checkOutput("job_accept drops with start", bus.job_accept, 1'b0);
        checkOutput("no extra job_accept", acceptPulses, 0);
        bus.config_valid = 4'b0001;
        #1;
        checkOutput("wp cleared after job", bus.config_accept, 4'b0001);
        bus.config_valid = 4'b0000;
        nextCycle();

        bus.job_parameters = {12'h000, 10'd3, 10'd0};
        bus.job_start      = 1'b1;
        #1;
        checkOutput("job2 accept", bus.job_accept, 1'b1);
        nextCycle();
        bus.job_start = 1'b0;
        #1;
        runRow(10, 2, 1'b0, 1'b1);
        checkOutput("job2 complete after short row", bus.job_complete, 1'b1);
        bus.job_complete_ack = 1'b1;
        nextCycle();
        bus.job_complete_ack = 1'b0;
        #1;
        checkOutput("job2 complete cleared", bus.job_complete, 1'b0);

        for (int cyc = 0; cyc < 60 && outIdx < 12; cyc++) begin
            bus.cascade_in_valid  = (inIdx < 12);
            bus.cascade_in_data   = cascadeWord(inIdx);
            bus.cascade_out_ready = ((cyc % 3) != 1);
            #1;
            if (cyc == 1) begin
                checkOutput("cascade latency valid", bus.cascade_out_valid, 1'b1);
                checkOutput("cascade latency data", bus.cascade_out_data, cascadeWord(0));
                checkOutput("cascade backpressure", bus.cascade_in_ready, 1'b0);
            end
            if (bus.cascade_out_valid && bus.cascade_out_ready) begin
                checkOutput($sformatf("cascade word %0d", outIdx), bus.cascade_out_data, cascadeWord(outIdx));
                outIdx++;
            end
            if (bus.cascade_in_valid && bus.cascade_in_ready) inIdx++;
            nextCycle();
        end
        checkOutput("cascade words out", outIdx, 12);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
